// File: rtl/sram_pkg.sv
// Shared SoC SRAM definitions: owner encodings and common bus widths.
// Latency: none (types and constants only).
// Backpressure: none.
package sram_pkg;

  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_BE_W   = 4;

  // Which master currently holds the SRAM slave port.
  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } sram_owner_e;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter in front of sram_sync32_async16: m0 = CPU data port, m1 = DMA/loader.
// Latency: owner's command passes through combinationally; rvalid one cycle after a completing read.
// Backpressure: owner waits on s_wait; non-owner waits on its own ce until ownership moves to it.
module sram_bus_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_ce,
  input  logic                   m0_wren,
  input  logic [ADDR_WIDTH-1:0]  m0_addr,
  input  logic [SRAM_BE_W-1:0]   m0_byteena,
  input  logic [SRAM_DATA_W-1:0] m0_wdata,
  output logic                   m0_wait,
  output logic                   m0_rvalid,
  input  logic                   m1_ce,
  input  logic                   m1_wren,
  input  logic [ADDR_WIDTH-1:0]  m1_addr,
  input  logic [SRAM_BE_W-1:0]   m1_byteena,
  input  logic [SRAM_DATA_W-1:0] m1_wdata,
  output logic                   m1_wait,
  output logic                   m1_rvalid,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic                   s_ce,
  output logic                   s_wren,
  output logic [ADDR_WIDTH-1:0]  s_addr,
  output logic [SRAM_BE_W-1:0]   s_byteena,
  output logic [SRAM_DATA_W-1:0] s_wdata,
  input  logic [SRAM_DATA_W-1:0] s_q,
  input  logic                   s_wait
);

  sram_owner_e owner;
  sram_owner_e owner_nxt;
  logic        owner_ce;
  logic        owner_wren;
  logic        other_ce;
  logic        xfer_done;

  assign owner_ce   = (owner == OWN1) ? m1_ce   : m0_ce;
  assign owner_wren = (owner == OWN1) ? m1_wren : m0_wren;
  assign other_ce   = (owner == OWN1) ? m0_ce   : m1_ce;
  assign xfer_done  = owner_ce & ~s_wait;

  // Owner register and read-valid pulses, credited to the owner at completion time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      owner     <= owner_nxt;
      m0_rvalid <= xfer_done & ~owner_wren & (owner == OWN0);
      m1_rvalid <= xfer_done & ~owner_wren & (owner == OWN1);
    end
  end

  // Hand over only at a transfer boundary: owner idle or completing, and the other side asking
  always_comb begin
    owner_nxt = owner;
    if (other_ce && (!owner_ce || xfer_done)) begin
      owner_nxt = (owner == OWN1) ? OWN0 : OWN1;
    end
  end

  // Slave command mux and wait generation; a non-owner is stalled for as long as it asks
  always_comb begin
    rdata     = s_q;
    s_ce      = m0_ce;
    s_wren    = m0_wren;
    s_addr    = m0_addr;
    s_byteena = m0_byteena;
    s_wdata   = m0_wdata;
    m0_wait   = m0_ce & s_wait;
    m1_wait   = m1_ce;
    if (owner == OWN1) begin
      s_ce      = m1_ce;
      s_wren    = m1_wren;
      s_addr    = m1_addr;
      s_byteena = m1_byteena;
      s_wdata   = m1_wdata;
      m0_wait   = m0_ce;
      m1_wait   = m1_ce & s_wait;
    end
  end

endmodule
